// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch request bundle (valid/ready/addr).
// Master is the fetch controller, slave is instruction memory.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC and fetch-request controller with stall/redirect/trap/halt priority.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects enter the trap vector.
module pc_fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_target,
    input  logic                  trap_valid,
    input  logic                  halt,
    input  logic                  resume,
    pc_fetch_ctrl_if.master       imem,
    output logic [XLEN-1:0]       PC,
    output logic [XLEN-1:0]       PCPlus4,
    output logic                  redirect_taken,
    output logic                  misalign,
    output logic [1:0]            pc_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_taken_q, redirect_taken_d;
    logic            misalign_d;
    logic            misaligned_redirect;
    logic            req_valid;
    logic            accept;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misaligned_redirect = redirect_valid &&
                                 (redirect_target[1:0] != 2'b00);
    assign misalign            = misalign_q;
`else
    assign misaligned_redirect = 1'b0;
    assign misalign            = 1'b0;
`endif

    assign req_valid = (state_q == RUN) && !stall;
    assign accept    = req_valid && imem.imem_req_ready;

    always_comb begin
        pc_d             = pc_q;
        state_d          = state_q;
        redirect_taken_d = 1'b0;
        misalign_d       = 1'b0;

        unique case (state_q)
            IDLE:    state_d = RUN;
            HALTED:  if (resume) state_d = RUN;
            default: ;
        endcase

        if (trap_valid || misaligned_redirect) begin
            pc_d             = TRAP_VECTOR;
            state_d          = RUN;
            redirect_taken_d = 1'b1;
            misalign_d       = misaligned_redirect;
        end else if (redirect_valid) begin
            pc_d             = {redirect_target[XLEN-1:2], 2'b00};
            redirect_taken_d = 1'b1;
        end else if (halt && state_q == RUN) begin
            state_d = HALTED;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (accept) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_VECTOR;
            state_q          <= IDLE;
            redirect_taken_q <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            state_q          <= state_d;
            redirect_taken_q <= redirect_taken_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
`endif

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;
    assign PC                  = pc_q;
    assign PCPlus4             = pc_q + XLEN'(4);
    assign redirect_taken      = redirect_taken_q;
    assign pc_state            = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed plan plus random traffic
// against a cycle-level reference model of the PC rules.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, trap_valid, halt, resume;
    logic [31:0] redirect_target;
    logic [31:0] PC, PCPlus4;
    logic        redirect_taken, misalign;
    logic [1:0]  pc_state;

    pc_fetch_ctrl_if #(.XLEN(32)) imem ();

    pc_fetch_ctrl #(
        .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid(trap_valid), .halt(halt), .resume(resume),
        .imem(imem.master),
        .PC(PC), .PCPlus4(PCPlus4),
        .redirect_taken(redirect_taken), .misalign(misalign),
        .pc_state(pc_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: state as small integers (0 idle, 1 run, 2 halted).
    int          m_st;
    logic [31:0] m_pc;
    bit          m_rt, m_ms;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int          st;
        logic [31:0] pc;
        bit          rt, ms, bad, fetch;
        st    = m_st;
        pc    = m_pc;
        rt    = 0;
        ms    = 0;
        fetch = (m_st == 1) && !stall && imem.imem_req_ready;
        bad   = MIS_EN && redirect_valid && (redirect_target % 4 != 0);
        if (m_st == 0) st = 1;
        if (m_st == 2 && resume) st = 1;
        if (reset) begin
            st = 0; pc = RV;
        end else if (trap_valid || bad) begin
            pc = TV; st = 1; rt = 1; ms = bad;
        end else if (redirect_valid) begin
            pc = redirect_target - (redirect_target % 4);
            rt = 1;
        end else if (halt && m_st == 1) begin
            st = 2;
        end else if (!stall && fetch) begin
            pc = m_pc + 4;
        end
        m_st = st; m_pc = pc; m_rt = rt; m_ms = ms;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("pc", PC, m_pc);
        check("addr", imem.imem_req_addr, m_pc);
        check("pc4", PCPlus4, m_pc + 32'd4);
        check("state", {30'd0, pc_state}, m_st);
        check("valid", {31'd0, imem.imem_req_valid},
              {31'd0, (m_st == 1) && !stall});
        check("rtaken", {31'd0, redirect_taken}, {31'd0, m_rt});
        check("misal", {31'd0, misalign}, {31'd0, m_ms});
    endtask

    task automatic idle_in();
        reset = 0; stall = 0; redirect_valid = 0; trap_valid = 0;
        halt = 0; resume = 0; redirect_target = 0;
        imem.imem_req_ready = 0;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid = 1; redirect_target = t;
        tick();
        redirect_valid = 0;
    endtask

    initial begin
        idle_in();
        m_st = 0; m_pc = RV; m_rt = 0; m_ms = 0;
        #1;
        reset = 1;
        tick();
        check("tp1_rst_state", {30'd0, pc_state}, 32'd0);
        check("tp1_rst_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        reset = 0;
        imem.imem_req_ready = 1;
        tick();
        check("tp1_pc0", PC, 32'h0);
        tick();
        check("tp1_pc4", PC, 32'h4);
        tick();
        tick();
        check("tp1_pcC", PC, 32'hC);

        imem.imem_req_ready = 0;
        redir(32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tp2_hold", imem.imem_req_addr, 32'h10);
        end
        imem.imem_req_ready = 1;
        tick();
        check("tp2_adv", PC, 32'h14);

        redir(32'h20);
        stall = 1;
        redir(32'h400);
        check("tp3_pc", PC, 32'h400);
        check("tp3_rt", {31'd0, redirect_taken}, 32'd1);
        tick();
        check("tp3_rt_off", {31'd0, redirect_taken}, 32'd0);
        check("tp3_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        stall = 0;

        imem.imem_req_ready = 0;
        trap_valid = 1;
        redir(32'h80);
        trap_valid = 0;
        check("tp4_trap_pc", PC, 32'h100);
        halt = 1;
        tick();
        halt = 0;
        check("tp4_halted", {30'd0, pc_state}, 32'd2);
        redir(32'h300);
        check("tp4_halt_redir", {30'd0, pc_state}, 32'd2);
        halt = 1; resume = 1;
        tick();
        halt = 0; resume = 0;
        check("tp4_resume", {30'd0, pc_state}, 32'd1);
        check("tp4_pc", PC, 32'h300);

        redir(32'hFFFF_FFFC);
        imem.imem_req_ready = 1;
        tick();
        check("tp5_wrap", PC, 32'h0);
        imem.imem_req_ready = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("tp5_rst_pc", PC, RV);
        check("tp5_rst_state", {30'd0, pc_state}, 32'd0);
        tick();

        redir(32'h202);
        check("tp6_pc", PC, MIS_EN ? 32'h100 : 32'h200);
        check("tp6_mis", {31'd0, misalign}, {31'd0, MIS_EN});
        tick();
        check("tp6_mis_off", {31'd0, misalign}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 99) < 2);
            stall           = ($urandom_range(0, 99) < 20);
            redirect_valid  = ($urandom_range(0, 99) < 10);
            redirect_target = $urandom;
            trap_valid      = ($urandom_range(0, 99) < 4);
            halt            = ($urandom_range(0, 99) < 6);
            resume          = ($urandom_range(0, 99) < 25);
            imem.imem_req_ready = ($urandom_range(0, 99) < 60);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter and fetch-request controller; successor to the bare PC register.
- Sits between the hazard/branch/trap logic and instruction memory.
- Drives the fetch address with a valid/ready handshake.
- Handles stall, branch/jump redirect, trap entry, and halt/resume with a fixed priority.

Parameters:
- XLEN, 32, width of PC and all addresses.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap entry (XLEN bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard freeze; holds PC and deasserts the fetch request.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  new PC for the redirect.
- trap_valid  in  1  trap entry request.
- halt  in  1  enter HALTED state.
- resume  in  1  leave HALTED state.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; always equal to PC.
- PC  out  XLEN  current program counter (registered).
- PCPlus4  out  XLEN  PC+4, combinational.
- redirect_taken  out  1  registered pulse; tells downstream to flush the in-flight fetch.
- misalign  out  1  registered pulse on a misaligned redirect; tied to 0 without the macro.
- pc_state  out  2  FSM state: 0 IDLE, 1 RUN, 2 HALTED.

Behaviour:
- Reset:
  - All state updates on the rising edge of clk only.
  - When reset=1 at an edge: PC<=RESET_VECTOR, pc_state<=IDLE, redirect_taken<=0, misalign<=0.
  - imem_req_valid is 0 while in IDLE.
  - Reset mid-operation overrides every other input; any in-flight fetch is abandoned.
- FSM:
  - IDLE -> RUN unconditionally on the next edge. This gives one bubble cycle after reset.
  - RUN -> HALTED when halt=1 and there is no trap and no redirect.
  - HALTED -> RUN when resume=1, or when trap_valid=1.
  - HALTED with redirect_valid=1: PC updated, stays HALTED.
  - halt and resume both 1 in HALTED: resume wins.
- Request: imem_req_valid = (pc_state==RUN) && !stall. Accept = imem_req_valid && imem_req_ready.
- Next-PC priority (highest first), evaluated every non-reset edge:
  1. trap_valid: PC<=TRAP_VECTOR, state<=RUN, redirect_taken<=1.
  2. redirect_valid: PC<=redirect_target with bits[1:0] forced to 0, redirect_taken<=1. Applies in any state and ignores stall and ready.
  3. halt (RUN only): PC held, state<=HALTED.
  4. stall: PC held.
  5. Accept: PC<=PC+4.
  6. Otherwise PC held; valid stays high and the address stays stable until accepted.
- Handshake: imem_req_addr must not change while imem_req_valid=1 and imem_req_ready=0, unless trap/redirect/reset. In that case redirect_taken marks the old request as stale.
- redirect_taken and misalign are 1 for exactly one cycle after the causing edge, then 0.
- Arithmetic: PC+4 is modulo 2^XLEN; 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
- Latency: the new PC is visible on PC/imem_req_addr in the cycle after the causing edge.
- Simultaneous events: trap+redirect -> trap wins. redirect+stall -> redirect wins. accept+stall cannot occur, because valid is 0 when stalled.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_target[1:0]!=0 is treated as a trap:
  - PC<=TRAP_VECTOR, state<=RUN.
  - misalign<=1 and redirect_taken<=1 for one cycle.
  - A simultaneous trap_valid gives the same result.
- Undefined: low two bits are silently cleared and misalign is constant 0.

Test Plan:
- Reset then ready=1 for 4 cycles -> PC 0x0 (cycle 1 valid=0, state IDLE), then 0x0, 0x4, 0x8, 0xC with valid=1.
- RUN at PC=0x10, ready=0 for 3 cycles -> imem_req_addr holds 0x10, valid=1; ready=1 -> PC=0x14 next cycle.
- PC=0x20, stall=1 with redirect_valid=1, target=0x400 -> next cycle PC=0x400, redirect_taken=1 for one cycle, valid=0 while stall remains high.
- trap_valid=1 and redirect_valid=1 (target 0x80) in the same cycle -> PC=0x100, redirect_taken=1; then halt=1 -> state HALTED, valid=0; resume=1 -> RUN, PC still 0x100.
- PC=32'hFFFF_FFFC accepted -> PC=0x0; reset asserted while ready=0 mid-request -> PC=RESET_VECTOR, state IDLE, valid=0.
- Redirect target 0x202: with PC_MISALIGN_TRAP_EN -> PC=0x100, misalign=1 for one cycle; without it -> PC=0x200, misalign=0.
